// File: rtl/primo_pkg.sv
// primo_pkg
// Shared constants for the sequential prime detector (primo_seq) and its
// bit-serial remainder unit (resto_seq).
//   DEFAULT_WIDTH        : default operand width in bits
//   ST_*                 : controller state encodings
//   SMALL_TWO/SMALL_THREE: small operands that the CHECK stage resolves directly
package primo_pkg;

   localparam int DEFAULT_WIDTH = 16;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_CHECK = 3'd1;
   localparam logic [STATE_W-1:0] ST_TEST  = 3'd2;
   localparam logic [STATE_W-1:0] ST_DIV   = 3'd3;
   localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

   localparam int SMALL_TWO   = 2;
   localparam int SMALL_THREE = 3;

endpackage

// File: rtl/resto_seq.sv
// resto_seq
// Bit-serial restoring remainder unit: computes dividend mod divisor, one
// quotient bit per clock.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   load      : start a new remainder computation (dividend sampled on this edge)
//   dividend  : WIDTH-bit dividend
//   divisor   : WIDTH-bit divisor, must be nonzero and held stable while busy
//   remainder : result, meaningful while valid=1
//   valid     : high for the single cycle in which remainder is final,
//               exactly WIDTH cycles after the load edge
module resto_seq
   import primo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] remainder,
   output logic             valid
);

   localparam int CNT_W = $clog2(WIDTH);

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             act_q, act_d;

   logic             shift_bit;
   logic [WIDTH-1:0] rem_base;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] step_rem;

   // One restoring step. The load edge already performs the first step so that
   // the last of the WIDTH steps lands on the edge that starts the valid cycle.
   // A borrow out of the (WIDTH+1)-bit subtraction means trial < divisor.
   always_comb begin
      shift_bit = load ? dividend[WIDTH-1] : quo_q[WIDTH-1];
      rem_base  = load ? '0 : rem_q;
      trial     = {rem_base, shift_bit};
      diff      = trial - {1'b0, divisor};
      step_rem  = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];

      rem_d = rem_q;
      quo_d = quo_q;
      cnt_d = cnt_q;
      act_d = act_q;

      if (load) begin
         rem_d = step_rem;
         quo_d = {dividend[WIDTH-2:0], 1'b0};
         cnt_d = CNT_W'(WIDTH - 1);
         act_d = 1'b1;
      end else if (act_q) begin
         if (cnt_q == '0) begin
            act_d = 1'b0;
         end else begin
            rem_d = step_rem;
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
         quo_q <= '0;
         cnt_q <= '0;
         act_q <= 1'b0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         cnt_q <= cnt_d;
         act_q <= act_d;
      end
   end

   assign remainder = rem_q;
   assign valid     = act_q && (cnt_q == '0);

endmodule

// File: rtl/primo_seq.sv
// primo_seq
// Sequential prime detector: accepts one WIDTH-bit operand through a
// start/done handshake and decides primality by odd trial division using the
// shared serial remainder unit resto_seq.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : request, sampled only while busy=0
//   n        : operand, captured on the accepting edge
//   busy     : high from the accept edge until the return to idle
//   done     : one-cycle result strobe
//   is_prime : registered result, held until the next result
//   factor   : smallest factor (n itself when prime, 0 for n<2); present
//              only when the macro PRIMO_FACTOR_EN is defined
module primo_seq
   import primo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] n,
   output logic             busy,
   output logic             done,
`ifdef PRIMO_FACTOR_EN
   output logic [WIDTH-1:0] factor,
`endif
   output logic             is_prime
);

   localparam logic [WIDTH-1:0] TWO_W   = WIDTH'(SMALL_TWO);
   localparam logic [WIDTH-1:0] THREE_W = WIDTH'(SMALL_THREE);

   logic [STATE_W-1:0] state_q, state_d;
   logic [WIDTH-1:0]   n_q, n_d;
   logic [WIDTH-1:0]   d_q, d_d;
   logic               pend_q, pend_d;
   logic               pend_prime_q, pend_prime_d;
   logic               prime_q, prime_d;
`ifdef PRIMO_FACTOR_EN
   logic [WIDTH-1:0]   pend_factor_q, pend_factor_d;
   logic [WIDTH-1:0]   factor_q, factor_d;
`endif

   logic [2*WIDTH-1:0] d_square;
   logic               div_load;
   logic [WIDTH-1:0]   div_rem;
   logic               div_valid;

   resto_seq #(
      .WIDTH (WIDTH)
   ) u_resto (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (div_load),
      .dividend  (n_q),
      .divisor   (d_q),
      .remainder (div_rem),
      .valid     (div_valid)
   );

   // Results found in CHECK or DIV are parked as "pending" and leave through
   // TEST, so every outcome reaches DONE exactly one cycle after the point at
   // which a TEST would have resolved it; this keeps latency uniform.
   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      d_d          = d_q;
      pend_d       = pend_q;
      pend_prime_d = pend_prime_q;
      prime_d      = prime_q;
`ifdef PRIMO_FACTOR_EN
      pend_factor_d = pend_factor_q;
      factor_d      = factor_q;
`endif
      div_load = 1'b0;
      d_square = {{WIDTH{1'b0}}, d_q} * {{WIDTH{1'b0}}, d_q};

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               n_d     = n;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            d_d          = WIDTH'(3);
            pend_d       = 1'b0;
            pend_prime_d = 1'b0;
`ifdef PRIMO_FACTOR_EN
            pend_factor_d = '0;
`endif
            if (n_q < TWO_W) begin
               pend_d = 1'b1;
            end else if ((n_q == TWO_W) || (n_q == THREE_W)) begin
               pend_d       = 1'b1;
               pend_prime_d = 1'b1;
`ifdef PRIMO_FACTOR_EN
               pend_factor_d = n_q;
`endif
            end else if (!n_q[0]) begin
               pend_d = 1'b1;
`ifdef PRIMO_FACTOR_EN
               pend_factor_d = TWO_W;
`endif
            end
            state_d = ST_TEST;
         end
         ST_TEST: begin
            if (pend_q) begin
               prime_d = pend_prime_q;
`ifdef PRIMO_FACTOR_EN
               factor_d = pend_factor_q;
`endif
               state_d = ST_DONE;
            end else if (d_square > {{WIDTH{1'b0}}, n_q}) begin
               prime_d = 1'b1;
`ifdef PRIMO_FACTOR_EN
               factor_d = n_q;
`endif
               state_d = ST_DONE;
            end else begin
               div_load = 1'b1;
               state_d  = ST_DIV;
            end
         end
         ST_DIV: begin
            if (div_valid) begin
               if (div_rem == '0) begin
                  pend_d       = 1'b1;
                  pend_prime_d = 1'b0;
`ifdef PRIMO_FACTOR_EN
                  pend_factor_d = d_q;
`endif
               end else begin
                  d_d = d_q + WIDTH'(2);
               end
               state_d = ST_TEST;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         n_q          <= '0;
         d_q          <= '0;
         pend_q       <= 1'b0;
         pend_prime_q <= 1'b0;
         prime_q      <= 1'b0;
`ifdef PRIMO_FACTOR_EN
         pend_factor_q <= '0;
         factor_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         d_q          <= d_d;
         pend_q       <= pend_d;
         pend_prime_q <= pend_prime_d;
         prime_q      <= prime_d;
`ifdef PRIMO_FACTOR_EN
         pend_factor_q <= pend_factor_d;
         factor_q      <= factor_d;
`endif
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign is_prime = prime_q;
`ifdef PRIMO_FACTOR_EN
   assign factor   = factor_q;
`endif

endmodule

// File: tb/tb_primo_seq.sv
// tb_primo_seq
// Scoreboard bench for primo_seq at WIDTH=16: each accepted request pushes its
// expected result and latency; a monitor pops and compares on every done.
// The factor output is checked only when PRIMO_FACTOR_EN is defined.
module tb_primo_seq;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] n;
   logic             busy;
   logic             done;
   logic             is_prime;
`ifdef PRIMO_FACTOR_EN
   logic [WIDTH-1:0] factor;
`endif

   typedef struct {
      int unsigned val;
      logic        prime;
      int unsigned fac;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   cycle  = 0;
   int   checks = 0;
   int   errors = 0;

   primo_seq #(
      .WIDTH (WIDTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .n        (n),
      .busy     (busy),
      .done     (done),
`ifdef PRIMO_FACTOR_EN
      .factor   (factor),
`endif
      .is_prime (is_prime)
   );

   // Free-running clock and cycle counter used for latency measurement.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycle <= cycle + 1;

   // Watchdog so the run always ends even if the design hangs.
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int unsigned val,
                              input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("[TB] FAIL %s (n=%0d): got %0d, expected %0d", name, val, act, expv);
      end
   endtask

   // Reference: plain odd trial division, with latency from the timing formula.
   function automatic void model(input int unsigned v, output logic p,
                                 output int unsigned f, output int l);
      int unsigned d;
      int          j;
      if (v < 2) begin
         p = 1'b0; f = 0; l = 2;
      end else if (v < 4) begin
         p = 1'b1; f = v; l = 2;
      end else if (v % 2 == 0) begin
         p = 1'b0; f = 2; l = 2;
      end else begin
         p = 1'b1; f = v; j = 0; d = 3;
         while (d * d <= v) begin
            j++;
            if (v % d == 0) begin
               p = 1'b0; f = d;
               break;
            end
            d += 2;
         end
         l = 2 + j * (WIDTH + 1);
      end
   endfunction

   // Waits (bounded) for the design to be idle, then issues one request and
   // records the expectation against the accepting edge.
   task automatic applyStimulus(input int unsigned val, input logic ep,
                                input int unsigned ef, input int el);
      exp_t e;
      int   guard = 0;
      @(negedge clk);
      while (busy && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (busy) checkOutput("idle_timeout", val, busy, 0);
      start = 1'b1;
      n     = WIDTH'(val);
      @(posedge clk);
      #1;
      e.val = val; e.prime = ep; e.fac = ef; e.lat = el; e.acc = cycle;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitIdle();
      int guard = 0;
      @(negedge clk);
      while (busy && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (busy) checkOutput("idle_timeout", 0, busy, 0);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done: got done=1, expected no pending request");
         end else begin
            e = sb.pop_front();
            checkOutput("is_prime", e.val, is_prime, e.prime);
            checkOutput("latency", e.val, cycle - e.acc, e.lat);
`ifdef PRIMO_FACTOR_EN
            checkOutput("factor", e.val, factor, e.fac);
`endif
         end
      end
   end

   initial begin
      logic        mp;
      int unsigned mf;
      int          ml;

      rst_n = 1'b0;
      start = 1'b0;
      n     = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 0, busy, 0);
      checkOutput("reset_done", 0, done, 0);
      checkOutput("reset_is_prime", 0, is_prime, 0);
`ifdef PRIMO_FACTOR_EN
      checkOutput("reset_factor", 0, factor, 0);
`endif
      rst_n = 1'b1;

      // Directed vectors, expected values worked out by hand.
      applyStimulus(0, 1'b0, 0, 2);
      applyStimulus(1, 1'b0, 0, 2);
      applyStimulus(2, 1'b1, 2, 2);
      applyStimulus(3, 1'b1, 3, 2);
      applyStimulus(4, 1'b0, 2, 2);
      applyStimulus(5, 1'b1, 5, 2);
      applyStimulus(7, 1'b1, 7, 2);
      applyStimulus(9, 1'b0, 3, 19);
      applyStimulus(10, 1'b0, 2, 2);
      applyStimulus(11, 1'b1, 11, 19);
      applyStimulus(25, 1'b0, 5, 36);
      applyStimulus(49, 1'b0, 7, 53);
      applyStimulus(121, 1'b0, 11, 87);

      // A start pulse during busy must not create a second request.
      applyStimulus(65535, 1'b0, 3, 19);
      repeat (4) @(negedge clk);
      start = 1'b1;
      n     = WIDTH'(7);
      @(negedge clk);
      start = 1'b0;

      applyStimulus(65521, 1'b1, 65521, 2161);

      // Same large prime, aborted by reset partway through.
      applyStimulus(65521, 1'b1, 65521, 2161);
      repeat (498) @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      #1;
      checkOutput("abort_busy", 65521, busy, 0);
      checkOutput("abort_done", 65521, done, 0);
      checkOutput("abort_is_prime", 65521, is_prime, 0);
`ifdef PRIMO_FACTOR_EN
      checkOutput("abort_factor", 65521, factor, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(9, 1'b0, 3, 19);

      // Back-to-back sweep of small operands against the reference model.
      for (int v = 0; v <= 300; v++) begin
         model(v, mp, mf, ml);
         applyStimulus(v, mp, mf, ml);
      end

      waitIdle();
      repeat (3) @(negedge clk);
      checkOutput("sb_drained", 0, sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
      $finish;
   end

endmodule
